// File: rtl/layer_pkg.sv
// Shared layer encodings and key indices for the layer request front end and
// the layer state machine it feeds.
package layer_pkg;

  localparam int NUM_KEYS = 4;
  localparam int KEY_NEXT = 3;

  typedef logic [2:0] layer_t;

  localparam layer_t LAYER_NONE = 3'b000;
  localparam layer_t LAYER_1    = 3'b001;
  localparam layer_t LAYER_2    = 3'b010;
  localparam layer_t LAYER_3    = 3'b100;

  // Anything that is not a legal one-hot layer restarts the rotation at layer 1.
  function automatic layer_t next_layer(input layer_t cur);
    layer_t nxt;
    case (cur)
      LAYER_1: nxt = LAYER_2;
      LAYER_2: nxt = LAYER_3;
      LAYER_3: nxt = LAYER_1;
      default: nxt = LAYER_1;
    endcase
    return nxt;
  endfunction

  function automatic layer_t resolve_request(input logic [NUM_KEYS-1:0] press,
                                             input layer_t              cur);
    layer_t req;
    req = LAYER_NONE;
    if (press[0])             req = LAYER_1;
    else if (press[1])        req = LAYER_2;
    else if (press[2])        req = LAYER_3;
    else if (press[KEY_NEXT]) req = next_layer(cur);
    return req;
  endfunction

endpackage

// File: rtl/layer_request_encoder_if.sv
// Key inputs, layer feedback and request outputs of the layer request encoder.
interface layer_request_encoder_if;
  import layer_pkg::*;

  logic [NUM_KEYS-1:0] key_n;
  layer_t              cur_layer;
  layer_t              layer_req;
  logic                req_valid;
  logic [NUM_KEYS-1:0] key_stable;

  modport master (
    output key_n,
    output cur_layer,
    input  layer_req,
    input  req_valid,
    input  key_stable
  );

  modport slave (
    input  key_n,
    input  cur_layer,
    output layer_req,
    output req_valid,
    output key_stable
  );
endinterface

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low pushbutton; emits a one-cycle
// pulse when a press is accepted.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic stable,
  output logic press
);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             sync_level;

  assign sync_level = ~sync2_q;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_level != stable_q) begin
      // Accept on the edge where the count would reach DEBOUNCE_CYCLES.
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync_level;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/layer_request_encoder.sv
// Turns four raw pushbuttons into a registered one-hot layer request pulse,
// with the next-layer key advancing relative to the fed-back current layer.
module layer_request_encoder
  import layer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  layer_request_encoder_if.slave  bus
);

  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] press;
  layer_t              req_d, req_q;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_key_debounce (
        .clk    (clk),
        .resetn (resetn),
        .key_n  (bus.key_n[gi]),
        .stable (stable[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  // Losing simultaneous presses are dropped, not queued.
  always_comb begin
    req_d = LAYER_NONE;
    req_d = resolve_request(press, bus.cur_layer);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q <= LAYER_NONE;
    end else begin
      req_q <= req_d;
    end
  end

  assign bus.layer_req  = req_q;
  assign bus.req_valid  = |req_q;
  assign bus.key_stable = stable;

endmodule
